// File: rtl/connect_four_ai_player_if.sv
// Connect-four AI player bus.
// Groups the game-side signals consumed by the AI opponent and the
// cursor/drop signals it produces.
//   master : game side (drives mode/pacing/board, observes AI outputs)
//   slave  : AI player (observes game state, drives cursor/drop/status)
// Signals:
//   enable         AI mode select
//   game_enable    slow pacing level (rising edge = one game tick)
//   winner_enable  game over flag
//   current_player 01 = P1, 10 = P2
//   board          board[row][col], 00 empty / 01 P1 / 10 P2, row 5 bottom
//   cursor_col     AI cursor column
//   drop_req       one-cycle drop request
//   busy           AI is anywhere but idle
//   chosen_col     last decided target column
interface connect_four_ai_player_if;
  logic                    enable;
  logic                    game_enable;
  logic                    winner_enable;
  logic [1:0]              current_player;
  logic [5:0][7:0][1:0]    board;
  logic [2:0]              cursor_col;
  logic                    drop_req;
  logic                    busy;
  logic [2:0]              chosen_col;

  modport master (
    output enable, game_enable, winner_enable, current_player, board,
    input  cursor_col, drop_req, busy, chosen_col
  );

  modport slave (
    input  enable, game_enable, winner_enable, current_player, board,
    output cursor_col, drop_req, busy, chosen_col
  );
endinterface

// File: rtl/connect_four_ai_player.sv
// Connect-four computer opponent.
// On its turn it waits a few game ticks, scans all 8 columns (one per clock)
// for an immediate win or a needed block, picks a column (win > block >
// centre preference), walks its cursor there one column per game tick and
// issues a single-cycle drop request, then waits for the turn to pass.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   ai_bus   slave side of connect_four_ai_player_if (see interface file)
module connect_four_ai_player #(
  parameter logic [1:0]  AI_PLAYER   = 2'b10,
  parameter int unsigned THINK_TICKS = 4,
  parameter int unsigned ACK_TICKS   = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  connect_four_ai_player_if.slave   ai_bus
);

  localparam logic [1:0] OPP_PLAYER = (AI_PLAYER == 2'b01) ? 2'b10 : 2'b01;
  localparam logic [3:0] THINK_LAST = 4'(THINK_TICKS - 1);
  localparam logic [3:0] ACK_LAST   = 4'(ACK_TICKS - 1);
  // Centre-first fallback order; element 0 is tried first.
  localparam logic [7:0][2:0] PREF_ORDER =
    {3'd7, 3'd0, 3'd6, 3'd1, 3'd5, 3'd2, 3'd4, 3'd3};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_THINK    = 3'd1,
    S_SCAN     = 3'd2,
    S_CHOOSE   = 3'd3,
    S_MOVE     = 3'd4,
    S_DROP     = 3'd5,
    S_WAIT_ACK = 3'd6
  } state_t;

  state_t      r_state;
  logic        r_game_enable_q;
  logic        r_tick;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_scan_col;
  logic [7:0]  r_legal_mask;
  logic        r_win_found;
  logic [2:0]  r_win_col;
  logic        r_blk_found;
  logic [2:0]  r_blk_col;
  logic [2:0]  r_cursor_col;
  logic [2:0]  r_chosen_col;
  logic        r_drop_req;
  logic        r_busy;

  logic [2:0]  w_land_row;
  logic        w_legal;
  logic        w_ai_win;
  logic        w_blk_win;
  logic        w_pref_valid;
  logic [2:0]  w_pref_col;
  logic [2:0]  w_target;

  // Contiguous p tokens from (r,c) stepping (dr,dc), at most 3, stopping at
  // the board edge or the first non-p cell.
  function automatic logic [1:0] run_len(
    input logic [5:0][7:0][1:0] b,
    input int r, input int c, input int dr, input int dc,
    input logic [1:0] p
  );
    logic [1:0] n;
    logic       go;
    int         rr;
    int         cc;
    n  = 2'd0;
    go = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      rr = r + dr * k;
      cc = c + dc * k;
      if (go && rr >= 0 && rr <= 5 && cc >= 0 && cc <= 7 &&
          b[rr[2:0]][cc[2:0]] == p) begin
        n = n + 2'd1;
      end else begin
        go = 1'b0;
      end
    end
    return n;
  endfunction

  // A drop at (row,col) wins for p if any line through it reaches 4.
  function automatic logic wins_at(
    input logic [5:0][7:0][1:0] b,
    input logic [2:0] row, input logic [2:0] col,
    input logic [1:0] p
  );
    int         r;
    int         c;
    logic [2:0] s_h;
    logic [2:0] s_v;
    logic [2:0] s_d;
    logic [2:0] s_a;
    r   = int'(row);
    c   = int'(col);
    s_h = {1'b0, run_len(b, r, c, 0, 1, p)} + {1'b0, run_len(b, r, c, 0, -1, p)};
    s_v = {1'b0, run_len(b, r, c, 1, 0, p)} + {1'b0, run_len(b, r, c, -1, 0, p)};
    s_d = {1'b0, run_len(b, r, c, 1, 1, p)} + {1'b0, run_len(b, r, c, -1, -1, p)};
    s_a = {1'b0, run_len(b, r, c, 1, -1, p)} + {1'b0, run_len(b, r, c, -1, 1, p)};
    return (s_h >= 3'd3) || (s_v >= 3'd3) || (s_d >= 3'd3) || (s_a >= 3'd3);
  endfunction

  // Evaluate the column currently under scan against the live board.
  always_comb begin
    w_land_row = 3'd0;
    for (int r = 0; r < 6; r++) begin
      if (ai_bus.board[3'(r)][r_scan_col] == 2'b00) begin
        w_land_row = 3'(r);
      end else begin
        w_land_row = w_land_row;
      end
    end
    w_legal   = (ai_bus.board[3'd0][r_scan_col] == 2'b00);
    w_ai_win  = w_legal && wins_at(ai_bus.board, w_land_row, r_scan_col, AI_PLAYER);
    w_blk_win = w_legal && wins_at(ai_bus.board, w_land_row, r_scan_col, OPP_PLAYER);
  end

  // Pick the target column from the scan results.
  always_comb begin
    w_pref_valid = 1'b0;
    w_pref_col   = 3'd0;
    // Walk the order backwards so the earliest legal entry is written last.
    for (int i = 7; i >= 0; i--) begin
      if (r_legal_mask[PREF_ORDER[i]]) begin
        w_pref_valid = 1'b1;
        w_pref_col   = PREF_ORDER[i];
      end else begin
        w_pref_valid = w_pref_valid;
      end
    end
    if (r_win_found) begin
      w_target = r_win_col;
    end else if (r_blk_found) begin
      w_target = r_blk_col;
    end else begin
      w_target = w_pref_col;
    end
  end

  // Registered rising-edge detect of the pacing level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_game_enable_q <= 1'b0;
      r_tick          <= 1'b0;
    end else begin
      r_game_enable_q <= ai_bus.game_enable;
      r_tick          <= ai_bus.game_enable & ~r_game_enable_q;
    end
  end

  // Turn sequencer: think, scan, choose, walk, drop, wait for the turn to pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= 4'd0;
      r_scan_col   <= 3'd0;
      r_legal_mask <= 8'd0;
      r_win_found  <= 1'b0;
      r_win_col    <= 3'd0;
      r_blk_found  <= 1'b0;
      r_blk_col    <= 3'd0;
      r_cursor_col <= 3'd0;
      r_chosen_col <= 3'd0;
      r_drop_req   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_drop_req <= 1'b0;
      if ((r_state != S_IDLE) && (!ai_bus.enable || ai_bus.winner_enable)) begin
        // Mode change or game over wins over everything; cursor stays put.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ai_bus.enable && !ai_bus.winner_enable &&
                ai_bus.current_player == AI_PLAYER) begin
              r_state    <= S_THINK;
              r_busy     <= 1'b1;
              r_tick_cnt <= 4'd0;
            end
          end
          S_THINK: begin
            if (r_tick) begin
              if (r_tick_cnt == THINK_LAST) begin
                r_state      <= S_SCAN;
                r_scan_col   <= 3'd0;
                r_legal_mask <= 8'd0;
                r_win_found  <= 1'b0;
                r_blk_found  <= 1'b0;
              end else begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
              end
            end
          end
          S_SCAN: begin
            r_legal_mask[r_scan_col] <= w_legal;
            // Only the lowest-index hit of each kind is kept.
            if (w_ai_win && !r_win_found) begin
              r_win_found <= 1'b1;
              r_win_col   <= r_scan_col;
            end
            if (w_blk_win && !r_blk_found) begin
              r_blk_found <= 1'b1;
              r_blk_col   <= r_scan_col;
            end
            if (r_scan_col == 3'd7) begin
              r_state <= S_CHOOSE;
            end else begin
              r_scan_col <= r_scan_col + 3'd1;
            end
          end
          S_CHOOSE: begin
            if (!w_pref_valid) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_chosen_col <= w_target;
              r_state      <= S_MOVE;
            end
          end
          S_MOVE: begin
            if (r_cursor_col == r_chosen_col) begin
              r_state    <= S_DROP;
              r_drop_req <= 1'b1;
            end else if (r_tick) begin
              if (r_cursor_col < r_chosen_col) begin
                r_cursor_col <= r_cursor_col + 3'd1;
              end else begin
                r_cursor_col <= r_cursor_col - 3'd1;
              end
            end
          end
          S_DROP: begin
            r_tick_cnt <= 4'd0;
            r_state    <= S_WAIT_ACK;
          end
          S_WAIT_ACK: begin
            if (ai_bus.current_player != AI_PLAYER) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (r_tick) begin
              if (r_tick_cnt == ACK_LAST) begin
                // Turn never passed: rescan from scratch and retry.
                r_state    <= S_THINK;
                r_tick_cnt <= 4'd0;
              end else begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ai_bus.cursor_col = r_cursor_col;
  assign ai_bus.drop_req   = r_drop_req;
  assign ai_bus.busy       = r_busy;
  assign ai_bus.chosen_col = r_chosen_col;

endmodule

// File: tb/tb_connect_four_ai_player.sv
// Self-checking bench for connect_four_ai_player: a table of board positions
// with hand-computed target columns, plus directed sequences for retry,
// abort, async reset, no-legal-column and game-over cases.
module tb_connect_four_ai_player;

  typedef struct {
    logic [5:0][7:0][1:0] board;
    logic [2:0]           exp_col;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   drop_count;
  logic [2:0] drop_cursor;
  vec_t vecs[6];

  connect_four_ai_player_if bus();

  connect_four_ai_player #(
    .AI_PLAYER  (2'b10),
    .THINK_TICKS(4),
    .ACK_TICKS  (8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ai_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count drop pulses and remember where the cursor was for each.
  always @(negedge clk) begin
    if (bus.drop_req === 1'b1) begin
      drop_count  = drop_count + 1;
      drop_cursor = bus.cursor_col;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One game tick: pacing high for one clock, then a long low gap.
  task automatic do_tick();
    @(posedge clk);
    #1 bus.game_enable = 1'b1;
    @(posedge clk);
    #1 bus.game_enable = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic set_play(input logic [5:0][7:0][1:0] b);
    bus.board          = b;
    bus.current_player = 2'b10;
    bus.enable         = 1'b1;
    bus.winner_enable  = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    int start;
    int n;
    do_reset();
    set_play(vecs[idx].board);
    start = drop_count;
    @(negedge clk);
    @(negedge clk);
    check($sformatf("v%0d_busy_think", idx), 32'(bus.busy), 32'd1);
    repeat (4) do_tick();
    check($sformatf("v%0d_chosen", idx), 32'(bus.chosen_col), 32'(vecs[idx].exp_col));
    check($sformatf("v%0d_cursor_start", idx), 32'(bus.cursor_col), 32'd0);
    n = 0;
    while (drop_count == start && n < 10) begin
      do_tick();
      n = n + 1;
    end
    check($sformatf("v%0d_move_ticks", idx), 32'(n), 32'(vecs[idx].exp_col));
    check($sformatf("v%0d_drops", idx), 32'(drop_count - start), 32'd1);
    check($sformatf("v%0d_drop_cursor", idx), 32'(drop_cursor), 32'(vecs[idx].exp_col));
    bus.current_player = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_busy_idle", idx), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [5:0][7:0][1:0] b;
    logic [5:0][7:0][1:0] empty_b;
    logic [5:0][7:0][1:0] full_b;
    int s;

    checks      = 0;
    errors      = 0;
    drop_count  = 0;
    drop_cursor = 3'd0;
    reset_n     = 1'b0;
    bus.game_enable    = 1'b0;
    bus.enable         = 1'b0;
    bus.winner_enable  = 1'b0;
    bus.current_player = 2'b01;
    empty_b = '0;
    bus.board = empty_b;

    // 0: empty board -> centre
    vecs[0].board = empty_b; vecs[0].exp_col = 3'd3;
    // 1: AI three at bottom left, P1 three above: win at 3
    b = empty_b;
    for (int c = 0; c < 3; c++) begin b[5][c] = 2'b10; b[4][c] = 2'b01; end
    vecs[1].board = b; vecs[1].exp_col = 3'd3;
    // 2: colours swapped: block at 3
    b = empty_b;
    for (int c = 0; c < 3; c++) begin b[5][c] = 2'b01; b[4][c] = 2'b10; end
    vecs[2].board = b; vecs[2].exp_col = 3'd3;
    // 3: P1 vertical threat in column 6
    b = empty_b;
    for (int r = 3; r < 6; r++) b[r][6] = 2'b01;
    vecs[3].board = b; vecs[3].exp_col = 3'd6;
    // 4: columns 3 and 4 full, no threats -> 2
    b = empty_b;
    for (int r = 0; r < 6; r++) begin
      b[r][3] = (r % 2 == 1) ? 2'b01 : 2'b10;
      b[r][4] = (r % 2 == 1) ? 2'b10 : 2'b01;
    end
    vecs[4].board = b; vecs[4].exp_col = 3'd2;
    // 5: AI vertical win in column 7 beats a lower block in column 3
    b = empty_b;
    for (int c = 0; c < 3; c++) b[5][c] = 2'b01;
    for (int r = 3; r < 6; r++) b[r][7] = 2'b10;
    vecs[5].board = b; vecs[5].exp_col = 3'd7;

    full_b = empty_b;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        full_b[r][c] = ((r + c) % 2 == 1) ? 2'b01 : 2'b10;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cursor", 32'(bus.cursor_col), 32'd0);
    check("rst_chosen", 32'(bus.chosen_col), 32'd0);
    check("rst_drop", 32'(bus.drop_req), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Retry: turn never passes, so a second drop follows a full rescan.
    do_reset();
    set_play(empty_b);
    s = drop_count;
    repeat (7) do_tick();
    check("retry_first_drop", 32'(drop_count - s), 32'd1);
    repeat (7) do_tick();
    check("retry_wait_busy", 32'(bus.busy), 32'd1);
    check("retry_no_early_drop", 32'(drop_count - s), 32'd1);
    repeat (4) do_tick();
    check("retry_still_thinking", 32'(drop_count - s), 32'd1);
    do_tick();
    check("retry_second_drop", 32'(drop_count - s), 32'd2);
    check("retry_drop_cursor", 32'(drop_cursor), 32'd3);

    // Abort mid-MOVE by dropping AI mode.
    do_reset();
    set_play(empty_b);
    s = drop_count;
    repeat (5) do_tick();
    check("abort_cursor_pre", 32'(bus.cursor_col), 32'd1);
    bus.enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_drop_low", 32'(bus.drop_req), 32'd0);
    repeat (4) do_tick();
    check("abort_cursor_frozen", 32'(bus.cursor_col), 32'd1);
    check("abort_no_drop", 32'(drop_count - s), 32'd0);

    // Async reset in the middle of a scan.
    do_reset();
    set_play(empty_b);
    repeat (7) do_tick();
    bus.current_player = 2'b01;
    repeat (2) @(posedge clk);
    #1 bus.current_player = 2'b10;
    repeat (3) do_tick();
    @(posedge clk);
    #1 bus.game_enable = 1'b1;
    @(posedge clk);
    #1 bus.game_enable = 1'b0;
    @(posedge clk);
    #3;
    check("arst_pre_busy", 32'(bus.busy), 32'd1);
    check("arst_pre_cursor", 32'(bus.cursor_col), 32'd3);
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_cursor", 32'(bus.cursor_col), 32'd0);
    check("arst_chosen", 32'(bus.chosen_col), 32'd0);
    check("arst_drop", 32'(bus.drop_req), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    s = drop_count;
    repeat (3) do_tick();
    check("arst_think_chosen", 32'(bus.chosen_col), 32'd0);
    check("arst_think_busy", 32'(bus.busy), 32'd1);
    do_tick();
    check("arst_after_think_chosen", 32'(bus.chosen_col), 32'd3);
    check("arst_no_drop_yet", 32'(drop_count - s), 32'd0);

    // Board full: nothing legal, never drops.
    do_reset();
    set_play(full_b);
    s = drop_count;
    repeat (6) do_tick();
    check("full_no_drop", 32'(drop_count - s), 32'd0);
    check("full_chosen", 32'(bus.chosen_col), 32'd0);
    check("full_cursor", 32'(bus.cursor_col), 32'd0);

    // Game over aborts thinking.
    do_reset();
    set_play(empty_b);
    @(negedge clk);
    @(negedge clk);
    check("win_pre_busy", 32'(bus.busy), 32'd1);
    bus.winner_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("win_abort_busy", 32'(bus.busy), 32'd0);
    bus.current_player = 2'b01;
    bus.winner_enable  = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
